// File: rtl/boron_dec_if.sv
// boron_dec_if
//   Request/response bundle between a BORON-64/80 decryption core and its user.
//   master : requester side. It drives ct_valid, ct, key and pt_ready, and
//            observes ct_ready, pt_valid and pt.
//   slave  : core side, the mirror image of master.
//   Signals:
//     ct_valid / ct_ready : request handshake (ciphertext + master key)
//     ct[63:0], key[79:0] : request payload
//     pt_valid / pt_ready : response handshake
//     pt[63:0]            : recovered plaintext
interface boron_dec_if;
    logic        ct_valid;
    logic        ct_ready;
    logic [63:0] ct;
    logic [79:0] key;
    logic        pt_valid;
    logic        pt_ready;
    logic [63:0] pt;

    modport master (
        output ct_valid, ct, key, pt_ready,
        input  ct_ready, pt_valid, pt
    );

    modport slave (
        input  ct_valid, ct, key, pt_ready,
        output ct_ready, pt_valid, pt
    );
endinterface

// File: rtl/boron_dec_core.sv
// boron_dec_core
//   Iterative BORON-64/80 decryption. A request is accepted in IDLE. The key
//   schedule is then run forward to K25, the K25 whitening is removed, and 25
//   inverse rounds follow while the schedule steps back from K24 to K0.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : boron_dec_if.slave, carrying the request and response handshakes
//     busy  : high while in KEYEXP, WHITEN or DEC
module boron_dec_core (
    input  logic        clk,
    input  logic        rst_n,
    boron_dec_if.slave  bus,
    output logic        busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] KEYEXP = 3'd1;
    localparam logic [2:0] WHITEN = 3'd2;
    localparam logic [2:0] DEC    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]  fsm;
    logic [4:0]  rc;
    logic [79:0] key_r;
    logic [63:0] state_r;
    logic [63:0] pt_r;
    logic        pt_valid_r;
    logic [63:0] dec_next;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] r;
        case (x)
            4'h0: r = 4'hE;  4'h1: r = 4'h4;  4'h2: r = 4'hB;  4'h3: r = 4'h1;
            4'h4: r = 4'h7;  4'h5: r = 4'h9;  4'h6: r = 4'hC;  4'h7: r = 4'hA;
            4'h8: r = 4'hD;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'hF;
            4'hC: r = 4'h8;  4'hD: r = 4'h5;  4'hE: r = 4'h3;  default: r = 4'h6;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] r;
        case (x)
            4'h0: r = 4'hA;  4'h1: r = 4'h3;  4'h2: r = 4'h9;  4'h3: r = 4'hE;
            4'h4: r = 4'h1;  4'h5: r = 4'hD;  4'h6: r = 4'hF;  4'h7: r = 4'h4;
            4'h8: r = 4'hC;  4'h9: r = 4'h5;  4'hA: r = 4'h7;  4'hB: r = 4'h2;
            4'hC: r = 4'h6;  4'hD: r = 4'h8;  4'hE: r = 4'h0;  default: r = 4'hB;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] inv_sub(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[n*4 +: 4] = inv_sbox(x[n*4 +: 4]);
        end
        return r;
    endfunction

    // Inverse linear layer: undo the word mix, rotate each word right, then
    // apply the nibble shuffle. Swapping nibbles 0<->2 and 1<->3 is the same
    // as swapping the two bytes of the word.
    function automatic logic [63:0] inv_perm(input logic [63:0] y);
        logic [15:0] a, b, c, d;
        logic [15:0] a1, b1, c1, d1;
        logic [15:0] a2, b2, c2, d2;
        a  = y[63:48];
        b  = y[47:32];
        c  = y[31:16];
        d  = y[15:0];
        a1 = a ^ b;
        b1 = b ^ c ^ d;
        c1 = a ^ b ^ c;
        d1 = c ^ d;
        a2 = {a1[6:0], a1[15:7]};
        b2 = {b1[8:0], b1[15:9]};
        c2 = {c1[3:0], c1[15:4]};
        d2 = {d1[0],   d1[15:1]};
        return {a2[7:0], a2[15:8], b2[7:0], b2[15:8],
                c2[7:0], c2[15:8], d2[7:0], d2[15:8]};
    endfunction

    // Forward schedule step f(K,i).
    function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] t;
        t         = {k[66:0], k[79:67]};
        t[3:0]    = sbox(t[3:0]);
        t[63:59]  = t[63:59] ^ i;
        return t;
    endfunction

    // Inverse schedule step g(K,i), the exact inverse of key_fwd.
    function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] t;
        t         = k;
        t[63:59]  = t[63:59] ^ i;
        t[3:0]    = inv_sbox(t[3:0]);
        return {t[12:0], t[79:13]};
    endfunction

    assign dec_next = inv_sub(inv_perm(state_r)) ^ key_r[63:0];

    assign bus.ct_ready = (fsm == IDLE);
    assign bus.pt_valid = pt_valid_r;
    assign bus.pt       = pt_r;
    assign busy         = (fsm == KEYEXP) || (fsm == WHITEN) || (fsm == DEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            rc         <= '0;
            key_r      <= '0;
            state_r    <= '0;
            pt_r       <= '0;
            pt_valid_r <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.ct_valid) begin
                        key_r   <= bus.key;
                        state_r <= bus.ct;
                        rc      <= 5'd0;
                        fsm     <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    key_r <= key_fwd(key_r, rc);
                    rc    <= rc + 5'd1;
                    // The last step (i = 24) leaves K25 in key_r.
                    if (rc == 5'd24) begin
                        fsm <= WHITEN;
                    end
                end
                WHITEN: begin
                    state_r <= state_r ^ key_r[63:0];
                    key_r   <= key_inv(key_r, 5'd24);
                    rc      <= 5'd24;
                    fsm     <= DEC;
                end
                DEC: begin
                    state_r <= dec_next;
                    if (rc != 5'd0) begin
                        key_r <= key_inv(key_r, rc - 5'd1);
                        rc    <= rc - 5'd1;
                    end else begin
                        pt_r       <= dec_next;
                        pt_valid_r <= 1'b1;
                        fsm        <= DONE;
                    end
                end
                DONE: begin
                    if (bus.pt_ready) begin
                        pt_valid_r <= 1'b0;
                        fsm        <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/boron_dec_core.md
# boron_dec_core

Iterative BORON-64/80 decryption core. It is the inverse of the encryption round datapath: it accepts an 80-bit master key and a 64-bit ciphertext and returns the 64-bit plaintext. It expands the key schedule forward to the last key, then runs 25 inverse rounds while stepping the schedule backward. It sits beside the encryption round logic in the cipher top level, behind a valid/ready handshake on both sides.

## Interface
- No parameters. Round count (25) and key width (80) are fixed.
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- ct_valid  in  1  ciphertext/key request valid
- ct_ready  out  1  core can accept a request; high only in IDLE
- ct  in  64  ciphertext
- key  in  80  master key K0
- pt_valid  out  1  plaintext valid; held until accepted
- pt_ready  in  1  consumer accepts plaintext
- pt  out  64  plaintext; registered
- busy  out  1  high in KEYEXP, WHITEN and DEC

## Operation
- Primitives:
  - S: 0..F → E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6.
  - InvS: 0..F → A,3,9,E,1,D,F,4,C,5,7,2,6,8,0,B. Applied to all 16 nibbles.
- Forward key step f(K,i), with i 5-bit:
  - K ← K rotl 13.
  - K[3:0] ← S(K[3:0]).
  - K[63:59] ^= i.
- Inverse key step g(K,i):
  - K[63:59] ^= i.
  - K[3:0] ← InvS(K[3:0]).
  - K ← K rotr 13.
  - g(f(K,i),i) = K exactly.
- Round keys: K_{i+1} = f(K_i, i) for i = 0..24. Round i uses K_i[63:0]. Whitening uses K25[63:0].
- InvP(y): words A=[63:48], B=[47:32], C=[31:16], D=[15:0].
  - Undo XOR mix: D'=C^D, A'=A^B, B'=B^C^D, C'=A^B^C.
  - Rotate right: A' by 7, B' by 9, C' by 4, D' by 1.
  - Block shuffle (self-inverse): in each 16-bit word, swap nibbles 0↔2 and 1↔3.
- FSM states: IDLE, KEYEXP, WHITEN, DEC, DONE.
  - IDLE: ct_ready=1. When ct_valid is high at an edge: key_r←key, state_r←ct, rc←0, go to KEYEXP.
  - KEYEXP: key_r←f(key_r, rc), rc←rc+1. On the edge where rc==24, go to WHITEN (key_r now holds K25).
  - WHITEN: state_r←state_r^key_r[63:0], key_r←g(key_r,24) (K24), rc←24, go to DEC.
  - DEC: state_r←InvS(InvP(state_r))^key_r[63:0].
    - If rc>0: key_r←g(key_r, rc−1), rc←rc−1.
    - If rc==0: pt←next state_r value, pt_valid←1, go to DONE.
  - DONE: hold pt and pt_valid. When pt_ready is high at an edge: pt_valid←0, go to IDLE.
- ct_valid is ignored outside IDLE. The request is sampled only on the accepting edge, so ct and key may change afterward.
- Reset (asynchronous, any state including mid-DEC):
  - Returns to IDLE; clears rc, key_r, state_r and pt to 0.
  - Outputs during reset: pt_valid=0, busy=0, pt=0, ct_ready=1.
  - A partial result is never emitted.

## Timing
- Accept edge E0.
- KEYEXP on edges E1..E25, WHITEN on E26, DEC on E27..E51.
- pt_valid rises after E51: 51 cycles accept-to-valid.
- Minimum request spacing is 53 cycles: pt_ready high at E52 returns to IDLE, so the earliest next accept is E53.
- ct_ready is combinational from state. pt_valid and pt are registered.
- busy goes high the cycle after the accept edge and low the cycle pt_valid rises.
- pt_ready while pt_valid=0 has no effect.
- Backpressure: DONE may last any number of cycles, and pt stays stable throughout.

## Test plan
- Round trip, zeros: key=80'h0, pt0=64'h0, encrypted by the bench model (existing encryption round + f schedule + K25 whitening). Require pt=64'h0 with pt_valid exactly 51 cycles after accept.
- Round trip, ones and a mixed vector:
  - key=80'hFFFF_FFFF_FFFF_FFFF_FFFF, pt0=64'hFFFF_FFFF_FFFF_FFFF.
  - key=80'h0123_4567_89AB_CDEF_0123, pt0=64'h0123_4567_89AB_CDEF.
  - Require recovered pt == pt0 for both.
- Primitive checks:
  - InvS(S(n))==n for all 16 nibbles.
  - InvP(P(x))==x for x=64'h1, 64'h8000_0000_0000_0000 and 200 random values.
  - g(f(K,i),i)==K for i=0..24 on random K.
- Handshake:
  - Hold pt_ready=0 for 10 cycles after pt_valid; pt must stay stable and ct_ready must stay 0.
  - A ct_valid pulse during DEC is ignored.
  - pt_ready=1 releases to IDLE; back-to-back requests spaced 53 cycles both decrypt correctly.
- Reset mid-operation:
  - Assert rst_n=0 at DEC cycle 10. Outputs go to 0 and ct_ready to 1 without waiting for a clock edge.
  - After release, a new request with key=80'h0 and the zero ciphertext yields pt=64'h0.
- Random soak: 1000 random key/plaintext pairs through the bench encryption model; all decrypt exactly with random pt_ready backpressure.
